// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared states, sizes and index/one-hot conversions for rr_onehot_arbiter
package rr_arb_pkg;

  localparam int RR_N  = 8;
  localparam int RR_PW = $clog2(RR_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Index to one-hot vector (the encoder's d input)
  function automatic logic [RR_N-1:0] onehot(input logic [RR_PW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // One-hot vector back to its index; only meaningful for a one-hot input
  function automatic logic [RR_PW-1:0] to_index(input logic [RR_N-1:0] vec);
    to_index = '0;
    for (int i = 0; i < RR_N; i++) begin
      if (vec[i]) to_index = RR_PW'(i);
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority picker starting at ptr
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N  = RR_N,
  parameter int PW = RR_PW
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] k,
  output logic          any
);

  // Walk offsets from farthest to nearest so the first set bit at or after ptr wins
  always_comb begin
    int idx;
    k   = '0;
    any = |req;
    idx = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) k = PW'(idx);
    end
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// rtl/rr_onehot_arbiter.sv - registered round-robin one-hot arbiter; optional grant timeout via RR_ARB_TIMEOUT_EN
module rr_onehot_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = RR_N,
  parameter int HOLD_MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         release_grant,
  output logic [N-1:0] grant,
  output logic         en,
  output logic         busy,
  output logic         timeout
);

  localparam int PW = RR_PW;

  state_t          state, state_nx;
  logic [PW-1:0]   ptr, ptr_nx;
  logic [PW-1:0]   pick_k;
  logic            pick_any;
  logic [PW-1:0]   cur_k;
  logic [N-1:0]    grant_nx;
  logic            en_nx, busy_nx, timeout_nx;
  logic            exit_norm;
  logic            exit_to;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr),
    .k   (pick_k),
    .any (pick_any)
  );

  // The grant register itself remembers who owns the bus
  assign cur_k     = to_index(grant);
  assign exit_norm = release_grant || !req[cur_k];

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] hold_cnt;

  assign exit_to = (state == GRANT) && (hold_cnt == CW'(HOLD_MAX - 1));

  // Grant-length counter: zero outside GRANT, counts up and saturates inside it
  always_ff @(posedge clk) begin
    if (rst || state != GRANT) begin
      hold_cnt <= '0;
    end else if (hold_cnt != {CW{1'b1}}) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign exit_to = 1'b0;
`endif

  // Next-state and next-output decode; outputs are registered below
  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    grant_nx   = grant;
    en_nx      = en;
    busy_nx    = busy;
    timeout_nx = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (pick_any) begin
          state_nx = GRANT;
          grant_nx = onehot(pick_k);
          en_nx    = 1'b1;
          busy_nx  = 1'b1;
        end else begin
          state_nx = IDLE;
          grant_nx = '0;
          en_nx    = 1'b0;
          busy_nx  = 1'b0;
        end
      end
      GRANT: begin
        if (exit_norm || exit_to) begin
          state_nx   = GAP;
          ptr_nx     = (cur_k == PW'(N - 1)) ? '0 : cur_k + 1'b1;
          grant_nx   = '0;
          en_nx      = 1'b0;
          busy_nx    = 1'b0;
          timeout_nx = exit_to && !exit_norm;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        en_nx    = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      grant   <= '0;
      en      <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      grant   <= grant_nx;
      en      <= en_nx;
      busy    <= busy_nx;
      timeout <= timeout_nx;
    end
  end

endmodule
